// File: rtl/lcd_pkg.sv
// lcd_pkg: message IDs, scheduler state encoding and a saturating counter helper
// shared by the LCD message scheduler files.
package lcd_pkg;
    localparam logic [1:0] MSG_ENGINE = 2'd0;
    localparam logic [1:0] MSG_BRAKE  = 2'd1;
    localparam logic [1:0] MSG_FUEL   = 2'd2;
    localparam logic [1:0] MSG_DASH   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_HOLD} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/lcd_msg_prio.sv
// lcd_msg_prio: 4-bit fixed-priority encoder, lowest set index wins.
module lcd_msg_prio
    import lcd_pkg::*;
(
    input  logic [3:0] req,
    output logic       any,
    output logic [1:0] idx
);
    always_comb begin
        any = |req;
        idx = req[0] ? MSG_ENGINE : req[1] ? MSG_BRAKE : req[2] ? MSG_FUEL : MSG_DASH;
    end
endmodule

// File: rtl/lcd_msg_scheduler.sv
// lcd_msg_scheduler: picks which message the LCD writer renders, holds it on screen,
// refreshes it periodically and flags writer timeouts.
module lcd_msg_scheduler
    import lcd_pkg::*;
#(
    parameter int HOLD_MS    = 1000,
    parameter int REFRESH_MS = 100,
    parameter int TIMEOUT_MS = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1ms,
    input  logic       lcd_ready,
    input  logic [3:0] req,
    input  logic       wr_done,
    output logic [1:0] sel_msg,
    output logic       wr_start,
    output logic       busy,
    output logic       err_timeout
);
    localparam logic [15:0] HOLD_L    = 16'(HOLD_MS);
    localparam logic [15:0] REFRESH_L = 16'(REFRESH_MS);
    localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT_MS);

    state_t      state_q;
    logic [1:0]  sel_q, last_q;
    logic        start_q, busy_q, err_q;
    logic [15:0] hold_q, ref_q, to_q;
    logic        any, preempt, release_c, refresh_c;
    logic [1:0]  idx;

    lcd_msg_prio u_prio (.req(req), .any(any), .idx(idx));

    always_comb begin
        preempt   = any && (idx < sel_q);
        release_c = !req[sel_q] && (hold_q >= HOLD_L);
        refresh_c = req[sel_q] && (ref_q >= REFRESH_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= MSG_DASH;
            last_q  <= MSG_DASH;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= '0;
            ref_q   <= '0;
            to_q    <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: if (lcd_ready && any) begin
                    sel_q   <= idx;
                    state_q <= S_START;
                    start_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                S_START: begin
                    to_q    <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: if (wr_done || (tick_1ms && (to_q + 16'd1 >= TIMEOUT_L))) begin
                    err_q   <= err_q | ~wr_done;
                    state_q <= S_HOLD;
                    busy_q  <= 1'b0;
                    ref_q   <= '0;
                    last_q  <= sel_q;
                    // Re-showing the same message keeps its accumulated on-screen time
                    if (last_q != sel_q) hold_q <= '0;
                end else if (tick_1ms) begin
                    to_q <= to_q + 16'd1;
                end
                S_HOLD: begin
                    if (tick_1ms) begin
                        hold_q <= sat_inc(hold_q);
                        ref_q  <= sat_inc(ref_q);
                    end
                    if (preempt || release_c) begin
                        state_q <= S_IDLE;
                    end else if (refresh_c) begin
                        state_q <= S_START;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sel_msg     = sel_q;
    assign wr_start    = start_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// tb_lcd_msg_scheduler: directed scenarios for the LCD message scheduler
// with HOLD_MS=10, REFRESH_MS=4, TIMEOUT_MS=3.
module tb_lcd_msg_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1ms = 1'b0;
    logic       lcd_ready = 1'b0;
    logic       wr_done = 1'b0;
    logic [3:0] req = 4'd0;
    logic [1:0] sel_msg;
    logic       wr_start, busy, err_timeout;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    lcd_msg_scheduler #(.HOLD_MS(10), .REFRESH_MS(4), .TIMEOUT_MS(3)) dut (
        .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .lcd_ready(lcd_ready), .req(req),
        .wr_done(wr_done), .sel_msg(sel_msg), .wr_start(wr_start), .busy(busy),
        .err_timeout(err_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_1ms = 1'b1;
        step();
        tick_1ms = 1'b0;
    endtask

    task automatic done();
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (sel_msg !== 2'd3) begin errors++; $display("FAIL reset_sel: got %0d want 3", sel_msg); end
        checks++; if (wr_start !== 1'b0) begin errors++; $display("FAIL reset_wr_start: got %b want 0", wr_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        rst = 1'b0;
    endtask

    task automatic test_ready_gate();
        logic seen = 1'b0;
        req = 4'b1000;
        lcd_ready = 1'b0;
        repeat (20) begin
            tick();
            seen |= wr_start;
            step();
            seen |= wr_start;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL gate_no_start: got %b want 0", seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_busy: got %b want 0", busy); end
        lcd_ready = 1'b1;
        step();
        checks++; if (wr_start !== 1'b1) begin errors++; $display("FAIL gate_start: got %b want 1", wr_start); end
        checks++; if (sel_msg !== 2'd3) begin errors++; $display("FAIL gate_sel: got %0d want 3", sel_msg); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gate_busy_start: got %b want 1", busy); end
        step();
        checks++; if (wr_start !== 1'b0) begin errors++; $display("FAIL gate_one_cycle: got %b want 0", wr_start); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gate_busy_wait: got %b want 1", busy); end
    endtask

    task automatic test_refresh();
        for (int r = 0; r < 2; r++) begin
            done();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL refresh_hold_busy[%0d]: got %b want 0", r, busy); end
            repeat (3) tick();
            step();
            checks++; if (wr_start !== 1'b0) begin errors++; $display("FAIL refresh_early[%0d]: got %b want 0", r, wr_start); end
            tick();
            step();
            checks++; if (wr_start !== 1'b1) begin errors++; $display("FAIL refresh_start[%0d]: got %b want 1", r, wr_start); end
            checks++; if (sel_msg !== 2'd3) begin errors++; $display("FAIL refresh_sel[%0d]: got %0d want 3", r, sel_msg); end
            step();
        end
    endtask

    task automatic test_preempt();
        done();
        req = 4'b1010;
        step();
        checks++; if (busy !== 1'b0 || wr_start !== 1'b0) begin errors++; $display("FAIL preempt_idle: got busy=%b start=%b want 0/0", busy, wr_start); end
        step();
        checks++; if (wr_start !== 1'b1) begin errors++; $display("FAIL preempt_start: got %b want 1", wr_start); end
        checks++; if (sel_msg !== 2'd1) begin errors++; $display("FAIL preempt_sel: got %0d want 1", sel_msg); end
        step();
        done();
    endtask

    task automatic test_release();
        logic seen = 1'b0;
        repeat (4) tick();
        step();
        checks++; if (wr_start !== 1'b1 || sel_msg !== 2'd1) begin errors++; $display("FAIL release_refresh: got start=%b sel=%0d want 1/1", wr_start, sel_msg); end
        step();
        done();
        tick();
        req = 4'b1000;
        repeat (4) begin
            tick();
            seen |= wr_start;
        end
        step();
        seen |= wr_start;
        step();
        seen |= wr_start;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL release_early: got %b want 0", seen); end
        checks++; if (sel_msg !== 2'd1) begin errors++; $display("FAIL release_kept: got %0d want 1", sel_msg); end
        tick();
        step();
        checks++; if (wr_start !== 1'b0) begin errors++; $display("FAIL release_idle: got %b want 0", wr_start); end
        step();
        checks++; if (wr_start !== 1'b1) begin errors++; $display("FAIL release_start: got %b want 1", wr_start); end
        checks++; if (sel_msg !== 2'd3) begin errors++; $display("FAIL release_sel: got %0d want 3", sel_msg); end
    endtask

    task automatic test_timeout();
        step();
        tick();
        tick();
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", err_timeout); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy: got %b want 1", busy); end
        tick();
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b want 1", err_timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_hold: got %b want 0", busy); end
        repeat (3) tick();
        step();
        checks++; if (wr_start !== 1'b0) begin errors++; $display("FAIL timeout_refresh_early: got %b want 0", wr_start); end
        tick();
        step();
        checks++; if (wr_start !== 1'b1 || sel_msg !== 2'd3) begin errors++; $display("FAIL timeout_refresh: got start=%b sel=%0d want 1/3", wr_start, sel_msg); end
        step();
        done();
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", err_timeout); end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        req = 4'b1100;
        step();
        step();
        step();
        checks++; if (busy !== 1'b1 || sel_msg !== 2'd2) begin errors++; $display("FAIL midrst_pre: got busy=%b sel=%0d want 1/2", busy, sel_msg); end
        rst = 1'b1;
        req = 4'b0000;
        step();
        checks++; if (sel_msg !== 2'd3) begin errors++; $display("FAIL midrst_sel: got %0d want 3", sel_msg); end
        checks++; if (busy !== 1'b0 || wr_start !== 1'b0) begin errors++; $display("FAIL midrst_busy: got busy=%b start=%b want 0/0", busy, wr_start); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", err_timeout); end
        rst = 1'b0;
        done();
        repeat (5) begin
            seen |= wr_start | busy;
            step();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_late_done: got %b want 0", seen); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL midrst_err_after: got %b want 0", err_timeout); end
    endtask

    initial begin
        test_reset();
        test_ready_gate();
        test_refresh();
        test_preempt();
        test_release();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
